// File: rtl/config_readback_tx_if.sv
// config_readback_tx_if
//   Bundles the two streams around config_readback_tx:
//     word side : word_data_i[31:0], word_valid_i -> word_ready_o
//     byte side : in_data_o[7:0], in_valid_o -> in_ready_i
//   Signal names keep the block's port names so traces read the same as the
//   block description. The "slave" modport is the readback block itself; the
//   "master" modport is whatever surrounds it (eFPGA word source + usb_cdc IN).
//
//   Handshake rule for both streams: a transfer happens at a rising edge where
//   valid & ready are both high; once valid is raised, valid and data hold
//   steady until that transfer; valid never depends combinationally on ready.
interface config_readback_tx_if;
  logic [31:0] word_data_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;

  modport master (
    output word_data_i, word_valid_i, in_ready_i,
    input  word_ready_o, in_data_o, in_valid_o
  );

  modport slave (
    input  word_data_i, word_valid_i, in_ready_i,
    output word_ready_o, in_data_o, in_valid_o
  );
endinterface

// File: rtl/config_readback_tx.sv
// config_readback_tx
//   Return path of the configuration link: buffers 32-bit readback/status
//   words from the eFPGA side in a small FIFO and serializes each one into
//   bytes for the usb_cdc IN channel.
//
// Parameters
//   FIFO_DEPTH : word FIFO depth, power of two, at least 2.
//   MSB_FIRST  : 1 sends bits [31:24] first, 0 sends bits [7:0] first.
//
// Ports
//   clk_i        : system clock, rising edge.
//   reset_i      : synchronous active-high reset.
//   bus          : config_readback_tx_if.slave (word stream in, byte stream out).
//   busy_o       : FIFO non-empty or a word is being sent.
//   word_count_o : words fully transmitted, wraps at 16 bits.
//   state_dbg_o  : current FSM state (0 = IDLE, 1 = SEND).
//
// Build option
//   READBACK_CHECKSUM_EN : when defined, every word is followed by a fifth
//   byte holding the XOR of its four data bytes, and the word is counted only
//   once that byte transfers.
module config_readback_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  config_readback_tx_if.slave  bus,
  output logic                 busy_o,
  output logic [15:0]          word_count_o,
  output logic                 state_dbg_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef READBACK_CHECKSUM_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shreg_q;
  logic [15:0] word_count_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full;
  logic        push, pop, xfer, word_done;
  logic [7:0]  lane;
  logic [7:0]  byte_out;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Ready comes only from registered pointers, so a pop in the same cycle
  // never opens room for a push into a full FIFO.
  assign push = bus.word_valid_i & ~full;
  assign xfer = (state_q == SEND) & bus.in_ready_i;

  // Next-state / control.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    pop        = 1'b0;
    word_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          byte_idx_d = 3'd0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (byte_idx_q == LAST) begin
            word_done  = 1'b1;
            byte_idx_d = 3'd0;
            // Reload straight from the FIFO so consecutive words stream
            // without an idle cycle between them.
            if (!empty) pop = 1'b1;
            else        state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      byte_idx_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // Datapath: pointers, shift register, counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      shreg_q      <= '0;
      word_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop) begin
        shreg_q  <= mem[rd_ptr_q[AW-1:0]];
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
      if (word_done) word_count_q <= word_count_q + 16'd1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= bus.word_data_i;
  end

  // Byte selection from the held word; driven to zero outside SEND.
  always_comb begin
    lane = 8'h00;
    case (byte_idx_q[1:0])
      2'd0: lane = MSB_FIRST ? shreg_q[31:24] : shreg_q[7:0];
      2'd1: lane = MSB_FIRST ? shreg_q[23:16] : shreg_q[15:8];
      2'd2: lane = MSB_FIRST ? shreg_q[15:8]  : shreg_q[23:16];
      default: lane = MSB_FIRST ? shreg_q[7:0] : shreg_q[31:24];
    endcase
    byte_out = lane;
`ifdef READBACK_CHECKSUM_EN
    if (byte_idx_q == LAST)
      byte_out = shreg_q[31:24] ^ shreg_q[23:16] ^ shreg_q[15:8] ^ shreg_q[7:0];
`endif
    if (state_q != SEND) byte_out = 8'h00;
  end

  assign bus.word_ready_o = ~full;
  assign bus.in_valid_o   = (state_q == SEND);
  assign bus.in_data_o    = byte_out;
  assign busy_o           = ~empty | (state_q == SEND);
  assign word_count_o     = word_count_q;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_config_readback_tx.sv
module tb_config_readback_tx;

`ifdef READBACK_CHECKSUM_EN
  localparam int BPW = 5;
`else
  localparam int BPW = 4;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  config_readback_tx_if bus ();
  config_readback_tx_if bus2 ();

  logic        busy, busy2, st, st2;
  logic [15:0] wc, wc2;

  logic rdy_fixed = 1'b0;
  bit   rdy_rand  = 1'b0;
  logic rdy       = 1'b0;
  assign bus.in_ready_i  = rdy;
  assign bus2.in_ready_i = rdy;

  config_readback_tx #(.FIFO_DEPTH(4), .MSB_FIRST(1'b1)) u_dut (
    .clk_i(clk), .reset_i(reset), .bus(bus.slave),
    .busy_o(busy), .word_count_o(wc), .state_dbg_o(st)
  );

  config_readback_tx #(.FIFO_DEPTH(2), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk_i(clk), .reset_i(reset), .bus(bus2.slave),
    .busy_o(busy2), .word_count_o(wc2), .state_dbg_o(st2)
  );

  // in_ready driver: fixed level or random, updated 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];   // {last byte of word, byte}
  logic [8:0] exp2_q[$];
  int words_done = 0, words_pushed = 0;
  int words2_done = 0, words2_pushed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: byte k of a word as it should appear on the wire.
  function automatic logic [7:0] model_byte(input logic [31:0] w, input bit msb, input int k);
    if (k == 4) return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    if (msb) return 8'(w >> (8 * (3 - k)));
    return 8'(w >> (8 * k));
  endfunction

  // ---------------- monitors ----------------
  logic       prev_stall = 1'b0, prev_stall2 = 1'b0;
  logic [7:0] prev_data, prev_data2;

  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_valid", 32'(bus.in_valid_o), 32'd1);
        check("hold_data", 32'(bus.in_data_o), 32'(prev_data));
      end
      if (bus.in_valid_o && rdy) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_byte actual=0x%0h required=none", bus.in_data_o);
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'(bus.in_data_o), 32'(e[7:0]));
          check("count_at_byte", 32'(wc), 32'(16'(words_done)));
          if (e[8]) words_done++;
        end
      end
      prev_stall = bus.in_valid_o & ~rdy;
      prev_data  = bus.in_data_o;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) prev_stall2 = 1'b0;
    else begin
      if (prev_stall2) begin
        check("hold_valid2", 32'(bus2.in_valid_o), 32'd1);
        check("hold_data2", 32'(bus2.in_data_o), 32'(prev_data2));
      end
      if (bus2.in_valid_o && rdy) begin
        if (exp2_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_byte2 actual=0x%0h required=none", bus2.in_data_o);
        end else begin
          e = exp2_q.pop_front();
          check("byte2", 32'(bus2.in_data_o), 32'(e[7:0]));
          check("count_at_byte2", 32'(wc2), 32'(16'(words2_done)));
          if (e[8]) words2_done++;
        end
      end
      prev_stall2 = bus2.in_valid_o & ~rdy;
      prev_data2  = bus2.in_data_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.word_valid_i  = 1'b0;
    bus2.word_valid_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp2_q.delete();
    words_done = 0; words_pushed = 0;
    words2_done = 0; words2_pushed = 0;
  endtask

  // Returns at the edge that accepted the word (+1 time unit).
  task automatic push1(input logic [31:0] w);
    bit ok = 1'b0;
    bus.word_data_i  = w;
    bus.word_valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.word_ready_o) begin ok = 1'b1; break; end
    end
    if (ok) begin
      for (int k = 0; k < BPW; k++) exp_q.push_back({k == BPW - 1, model_byte(w, 1'b1, k)});
      words_pushed++;
    end else begin
      total++; bad++;
      $display("FAIL push_timeout actual=not_ready required=ready");
    end
    @(posedge clk); #1;
    bus.word_valid_i = 1'b0;
  endtask

  task automatic push2(input logic [31:0] w);
    bit ok = 1'b0;
    bus2.word_data_i  = w;
    bus2.word_valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus2.word_ready_o) begin ok = 1'b1; break; end
    end
    if (ok) begin
      for (int k = 0; k < BPW; k++) exp2_q.push_back({k == BPW - 1, model_byte(w, 1'b0, k)});
      words2_pushed++;
    end else begin
      total++; bad++;
      $display("FAIL push2_timeout actual=not_ready required=ready");
    end
    @(posedge clk); #1;
    bus2.word_valid_i = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && exp2_q.size() == 0 && !busy && !busy2) break;
    end
    check(name, 32'(exp_q.size() + exp2_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w0;
    bus.word_data_i   = '0;
    bus.word_valid_i  = 1'b0;
    bus2.word_data_i  = '0;
    bus2.word_valid_i = 1'b0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_word_ready", 32'(bus.word_ready_o), 32'd1);
    check("rst_in_valid", 32'(bus.in_valid_o), 32'd0);
    check("rst_in_data", 32'(bus.in_data_o), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(wc), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);

    // Latency and basic ordering, in_ready held high.
    @(posedge clk); #1 rdy_fixed = 1'b1;
    push1(32'hA1B2C3D4);
    @(negedge clk);
    check("lat_t1_valid", 32'(bus.in_valid_o), 32'd0);
    check("lat_t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_t2_valid", 32'(bus.in_valid_o), 32'd1);
    repeat (BPW - 1) @(negedge clk);
    check("last_byte_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("after_word_busy", 32'(busy), 32'd0);
    check("after_word_valid", 32'(bus.in_valid_o), 32'd0);
    check("after_word_count", 32'(wc), 32'(16'(words_pushed)));
    check("after_word_queue", 32'(exp_q.size()), 32'd0);

    // Fill: in_ready low, 5 words -> one in flight, four queued.
    do_reset();
    rdy_fixed = 1'b0;
    @(posedge clk); #1;
    w0 = $urandom;
    push1(w0);
    for (int i = 0; i < 4; i++) push1($urandom);
    bus.word_data_i  = 32'hDEADBEEF;
    bus.word_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_ready", 32'(bus.word_ready_o), 32'd0);
      check("stall_data", 32'(bus.in_data_o), 32'(model_byte(w0, 1'b1, 0)));
    end
    @(posedge clk); #1;
    bus.word_valid_i = 1'b0;
    rdy_fixed = 1'b1;
    repeat (5 * BPW) @(posedge clk);
    #1;
    check("stream_no_bubble", 32'(exp_q.size()), 32'd0);
    check("stream_count", 32'(wc), 32'd5);
    check("stream_busy", 32'(busy), 32'd0);

    // Reset mid-word with two words queued.
    rdy_fixed = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push1($urandom);
    rdy_fixed = 1'b1;
    repeat (2) @(posedge clk);
    #1 rdy_fixed = 1'b0;
    do_reset();
    @(negedge clk);
    check("midrst_valid", 32'(bus.in_valid_o), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(wc), 32'd0);
    check("midrst_ready", 32'(bus.word_ready_o), 32'd1);
    @(posedge clk); #1 rdy_fixed = 1'b1;
    push1(32'hCAFEF00D);
    drain("midrst_drain", 100);
    check("midrst_new_count", 32'(wc), 32'(16'(words_pushed)));

    // Random stalls with gaps between words.
    rdy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      push1($urandom);
    end
    drain("rand_drain", 3000);
    check("rand_count", 32'(wc), 32'(16'(words_pushed)));

    // LSB-first instance, depth 2.
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b1;
    @(posedge clk); #1;
    push2(32'h11223344);
    drain("lsb_drain", 100);
    check("lsb_count", 32'(wc2), 32'd1);
    rdy_rand = 1'b1;
    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      push2($urandom);
    end
    drain("lsb_rand_drain", 1000);
    check("lsb_rand_count", 32'(wc2), 32'(16'(words2_pushed)));
    rdy_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
